// File: rtl/stream_arb_pkg.sv
// Shared types and width helpers for the round-robin stream arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package stream_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Must hold the value BURST itself, not just BURST-1.
  function automatic int cnt_w(input int burst);
    return $clog2(burst + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority pick: first requester at or after ptr, wrapping modulo N.
// Latency: combinational.
// Backpressure: none; pure selector.
module rr_pick
  import stream_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);

  int            cand;
  logic [IW-1:0] cand_idx;

  // Walk offsets from far to near so the nearest requester overwrites last.
  always_comb begin
    any      = |req;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = int'(ptr) + i;
      if (cand >= N) cand = cand - N;
      cand_idx = cand[IW-1:0];
      if (req[cand_idx]) idx = cand_idx;
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin N:1 valid/ready stream arbiter with a one-deep registered output.
// Latency: 1 cycle arbitration (IDLE -> GRANT), 1 cycle input beat to out_valid/out_data.
// Backpressure: in_ready of the granted source = !out_valid || out_ready; others held at 0.
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int BURST = 16
) (
  input  logic                  clk,
  input  logic                  s_rst,
  input  logic [N-1:0]          in_valid,
  input  logic [N*WIDTH-1:0]    in_data,
  output logic [N-1:0]          in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  out_ready,
  output logic [idx_w(N)-1:0]   grant_id,
  output logic                  busy
);

  localparam int            IW      = idx_w(N);
  localparam int            CW      = cnt_w(BURST);
  localparam logic [IW-1:0] LAST    = IW'(N - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST);

  arb_state_t       state, state_nxt;
  logic [IW-1:0]    ptr, ptr_nxt, grant_nxt;
  logic [CW-1:0]    beat_cnt, beat_cnt_nxt;
  logic             pick_any;
  logic [IW-1:0]    pick_idx;
  logic             src_vld, take, hs;
  logic [WIDTH-1:0] src_dat;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req (in_valid),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    src_vld            = in_valid[grant_id];
    src_dat            = in_data[grant_id*WIDTH +: WIDTH];
    take               = (state == GRANT) && (!out_valid || out_ready);
    hs                 = take && src_vld;
    in_ready           = '0;
    in_ready[grant_id] = take;
  end

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    grant_nxt    = grant_id;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt    = GRANT;
          grant_nxt    = pick_idx;
          beat_cnt_nxt = '0;
        end
      end
      GRANT: begin
        if (hs) beat_cnt_nxt = beat_cnt + 1'b1;
        // A dropped valid forfeits the grant even if the burst is not spent.
        if (!src_vld || (hs && beat_cnt_nxt == CNT_MAX)) begin
          state_nxt = IDLE;
          ptr_nxt   = (grant_id == LAST) ? '0 : grant_id + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (s_rst) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_id  <= '0;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      grant_id <= grant_nxt;
      beat_cnt <= beat_cnt_nxt;
      // The output slot drains on its own schedule, independent of releases.
      if (hs) begin
        out_valid <= 1'b1;
        out_data  <= src_dat;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = (state == GRANT);

endmodule
